// File: rtl/multicycle_control.sv
// Main control unit for the multicycle MIPS core: Moore FSM, ALU decoder,
// overflow-suppressed writeback and a sticky trap flag.
module multicycle_control (
    input  logic       ck,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       overflow,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegDest,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       Branch,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    state_t     state_q, state_d;
    logic       ovf_q, ovf_d;
    logic       trap_q, trap_d;
    logic [1:0] alu_op;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
               (f == F_OR)  || (f == F_SLT);
    endfunction

    function automatic logic funct_arith(input logic [5:0] f);
        return (f == F_ADD) || (f == F_SUB);
    endfunction

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ovf_q   <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            trap_q  <= trap_d;
        end
    end

    // Next state, overflow capture and trap accumulation.
    always_comb begin
        state_d = FETCH;
        ovf_d   = ovf_q;
        trap_d  = trap_q;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d = FETCH;
                        trap_d  = 1'b1;
                    end
                endcase
            end
            MEMADR:   state_d = (Op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = MEMWB;
            EXECUTE: begin
                state_d = ALUWB;
                ovf_d   = overflow & funct_arith(Funct);
                if (!funct_legal(Funct) || ovf_d)
                    trap_d = 1'b1;
            end
            ADDIEXEC: begin
                state_d = ADDIWB;
                ovf_d   = overflow;
                if (overflow)
                    trap_d = 1'b1;
            end
            default:  state_d = FETCH;
        endcase
        // Every return to FETCH starts the next instruction with a clean flag.
        if (state_d == FETCH)
            ovf_d = 1'b0;
    end

    // Moore outputs decoded from the state register only (plus ovf_q).
    always_comb begin
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        RegDest  = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        Branch   = 1'b0;
        PCWrite  = 1'b0;
        MemWrite = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        alu_op   = 2'b00;
        case (state_q)
            FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            DECODE:   ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMREAD:  IorD = 1'b1;
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b10;
            end
            ALUWB: begin
                RegDest  = 1'b1;
                RegWrite = !ovf_q;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b01;
                Branch  = 1'b1;
                PCSrc   = 2'b01;
            end
            ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB:   RegWrite = !ovf_q;
            JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            default: ;
        endcase
    end

    // ALU decoder; unknown functs fall back to add.
    always_comb begin
        ALUControl = 3'b010;
        case (alu_op)
            2'b01: ALUControl = 3'b110;
            2'b10: begin
                case (Funct)
                    F_ADD:   ALUControl = 3'b010;
                    F_SUB:   ALUControl = 3'b110;
                    F_AND:   ALUControl = 3'b000;
                    F_OR:    ALUControl = 3'b001;
                    F_SLT:   ALUControl = 3'b111;
                    default: ALUControl = 3'b010;
                endcase
            end
            default: ALUControl = 3'b010;
        endcase
    end

    assign trap  = trap_q;
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction expected control
// sequences from a behavioural model, plus literal state-sequence pins.
module tb_multicycle_control;

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Op = 6'b0;
    logic [5:0] Funct = 6'b0;
    logic       overflow = 1'b0;
    logic       IorD, IRWrite, RegDest, MemtoReg, RegWrite, ALUSrcA;
    logic       Branch, PCWrite, MemWrite, trap;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;
    logic trap_m = 1'b0;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_ADDI = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

    typedef struct packed {
        logic [3:0] st;
        logic       iord, irwrite, regdest, memtoreg, regwrite, alusrca, branch, pcwrite, memwrite;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] aluctl;
    } exp_t;

    multicycle_control dut (
        .ck(ck), .reset(reset), .Op(Op), .Funct(Funct), .overflow(overflow),
        .IorD(IorD), .IRWrite(IRWrite), .RegDest(RegDest), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .Branch(Branch), .PCWrite(PCWrite),
        .MemWrite(MemWrite), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .ALUControl(ALUControl), .trap(trap), .state(state)
    );

    always #5 ck = ~ck;

    function automatic logic [5:0] op_of(input int kind);
        case (kind)
            K_LW:    return 6'b100011;
            K_SW:    return 6'b101011;
            K_R:     return 6'b000000;
            K_ADDI:  return 6'b001000;
            K_BEQ:   return 6'b000100;
            K_J:     return 6'b000010;
            default: return 6'b111111;
        endcase
    endfunction

    function automatic int latency(input int kind);
        case (kind)
            K_LW:               return 5;
            K_SW, K_R, K_ADDI:  return 4;
            K_BEQ, K_J:         return 3;
            default:            return 2;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic r_legal(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    // What the controls must be on cycle k of an instruction of this kind.
    function automatic exp_t expect_cycle(input int kind, input int k, input logic [5:0] f, input logic ovf);
        exp_t e;
        e = '0;
        e.aluctl = 3'b010;
        if (k == 0) begin
            e.st = 4'd0; e.irwrite = 1; e.pcwrite = 1; e.alusrcb = 2'b01;
        end else if (k == 1) begin
            e.st = 4'd1; e.alusrcb = 2'b11;
        end else begin
            case (kind)
                K_LW, K_SW: begin
                    if (k == 2) begin
                        e.st = 4'd2; e.alusrca = 1; e.alusrcb = 2'b10;
                    end else if (kind == K_SW) begin
                        e.st = 4'd5; e.iord = 1; e.memwrite = 1;
                    end else if (k == 3) begin
                        e.st = 4'd3; e.iord = 1;
                    end else begin
                        e.st = 4'd4; e.memtoreg = 1; e.regwrite = 1;
                    end
                end
                K_R: begin
                    if (k == 2) begin
                        e.st = 4'd6; e.alusrca = 1; e.aluctl = r_alu(f);
                    end else begin
                        e.st = 4'd7; e.regdest = 1;
                        e.regwrite = !(ovf && (f == 6'b100000 || f == 6'b100010));
                    end
                end
                K_ADDI: begin
                    if (k == 2) begin
                        e.st = 4'd9; e.alusrca = 1; e.alusrcb = 2'b10;
                    end else begin
                        e.st = 4'd10; e.regwrite = !ovf;
                    end
                end
                K_BEQ: begin
                    e.st = 4'd8; e.alusrca = 1; e.branch = 1; e.pcsrc = 2'b01; e.aluctl = 3'b110;
                end
                default: begin
                    e.st = 4'd11; e.pcwrite = 1; e.pcsrc = 2'b10;
                end
            endcase
        end
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.st = state; o.iord = IorD; o.irwrite = IRWrite; o.regdest = RegDest;
        o.memtoreg = MemtoReg; o.regwrite = RegWrite; o.alusrca = ALUSrcA;
        o.branch = Branch; o.pcwrite = PCWrite; o.memwrite = MemWrite;
        o.alusrcb = ALUSrcB; o.pcsrc = PCSrc; o.aluctl = ALUControl;
        return o;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Runs one instruction starting just after a negedge in FETCH; returns
    // the observed state sequence packed one nibble per cycle.
    task automatic run_instr(input int kind, input logic [5:0] f, input logic ovf,
                             input string nm, output logic [31:0] seq);
        exp_t e;
        seq = '0;
        Op = op_of(kind);
        Funct = f;
        overflow = 1'b0;
        for (int k = 0; k < latency(kind); k++) begin
            e = expect_cycle(kind, k, f, ovf);
            check($sformatf("%s.c%0d.ctl", nm, k), 32'(observed()), 32'(e));
            check($sformatf("%s.c%0d.trap", nm, k), 32'(trap), 32'(trap_m));
            seq = {seq[27:0], state};
            overflow = (k == 2 && (kind == K_R || kind == K_ADDI)) ? ovf : 1'b0;
            @(posedge ck);
            if (k == 1 && kind == K_ILL) trap_m = 1'b1;
            if (k == 2 && kind == K_R && (!r_legal(f) || (ovf && (f == 6'b100000 || f == 6'b100010))))
                trap_m = 1'b1;
            if (k == 2 && kind == K_ADDI && ovf) trap_m = 1'b1;
            @(negedge ck);
            overflow = 1'b0;
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        @(negedge ck);
        reset = 1'b0;
        trap_m = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] seq;
        #2;
        check("rst.state", 32'(state), 32'd0);
        check("rst.irwrite", 32'(IRWrite), 32'd1);
        check("rst.pcwrite", 32'(PCWrite), 32'd1);
        check("rst.alusrcb", 32'(ALUSrcB), 32'd1);
        check("rst.aluctl", 32'(ALUControl), 32'b010);
        check("rst.trap", 32'(trap), 32'd0);
        check("rst.regwrite", 32'(RegWrite), 32'd0);
        do_reset();

        run_instr(K_LW, 6'b0, 1'b0, "lw", seq);
        check("lw.seq", seq, 32'h0001_2340 >> 4);
        check("lw.back", 32'(state), 32'd0);
        run_instr(K_R, 6'b101010, 1'b0, "slt", seq);
        check("slt.seq", seq, 32'h0167);
        run_instr(K_ADDI, 6'b0, 1'b1, "addi_ovf", seq);
        check("addi.seq", seq, 32'h019A);
        check("addi.trap", 32'(trap), 32'd1);
        run_instr(K_LW, 6'b0, 1'b0, "lw_after_trap", seq);
        check("trap.sticky", 32'(trap), 32'd1);
        do_reset();
        check("trap.cleared", 32'(trap), 32'd0);

        run_instr(K_BEQ, 6'b0, 1'b0, "beq", seq);
        check("beq.seq", seq, 32'h018);
        run_instr(K_J, 6'b0, 1'b0, "j", seq);
        check("j.seq", seq, 32'h01B);
        run_instr(K_SW, 6'b0, 1'b0, "sw", seq);
        check("sw.seq", seq, 32'h0125);
        run_instr(K_ADDI, 6'b0, 1'b0, "addi", seq);
        check("addi.notrap", 32'(trap), 32'd0);
        run_instr(K_R, 6'b100100, 1'b0, "and", seq);
        run_instr(K_R, 6'b100101, 1'b1, "or_ovf_ignored", seq);
        check("or.notrap", 32'(trap), 32'd0);
        run_instr(K_R, 6'b100010, 1'b1, "sub_ovf", seq);
        check("sub.trap", 32'(trap), 32'd1);
        do_reset();
        run_instr(K_R, 6'b000111, 1'b0, "bad_funct", seq);
        check("badf.trap", 32'(trap), 32'd1);
        do_reset();
        run_instr(K_ILL, 6'b0, 1'b0, "illegal", seq);
        check("ill.seq", seq, 32'h01);
        check("ill.state", 32'(state), 32'd0);
        check("ill.trap", 32'(trap), 32'd1);
        do_reset();

        // Asynchronous reset while in MEMREAD.
        Op = 6'b100011;
        repeat (3) begin
            @(posedge ck);
            @(negedge ck);
        end
        #1;
        check("mid.memread", 32'(state), 32'd3);
        reset = 1'b1;
        #1;
        check("mid.state", 32'(state), 32'd0);
        check("mid.irwrite", 32'(IRWrite), 32'd1);
        check("mid.iord", 32'(IorD), 32'd0);
        @(negedge ck);
        reset = 1'b0;
        trap_m = 1'b0;
        #1;
        run_instr(K_LW, 6'b0, 1'b0, "lw_after_mid", seq);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
